// File: rtl/pid_multi.sv
// pid_multi: time-multiplexed N_CH-channel PID controller sharing a single signed multiplier.
// Optional integral anti-windup is enabled by defining PID_ANTIWINDUP_EN.
module pid_multi #(
    parameter int D_WIDTH   = 16,
    parameter int N_CH      = 4,
    parameter int FRAC_BITS = 8,
    parameter int INT_WIDTH = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_enable,
    input  logic [15:0]               reg_addr,
    input  logic [15:0]               reg_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [3:0]                sample_ch,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic signed [D_WIDTH-1:0] measurement,
    output logic                      out_valid,
    output logic [3:0]                out_ch,
    output logic signed [D_WIDTH-1:0] out
);
    localparam int E_W   = D_WIDTH + 1;
    localparam int DD_W  = D_WIDTH + 2;
    localparam int OP_W  = (INT_WIDTH > DD_W) ? INT_WIDTH : DD_W;
    localparam int P_W   = D_WIDTH + OP_W;
    localparam int SUM_W = P_W + 2;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SAT} state_t;
    state_t state;

    logic signed [D_WIDTH-1:0]   kp [N_CH];
    logic signed [D_WIDTH-1:0]   ki [N_CH];
    logic signed [D_WIDTH-1:0]   kd [N_CH];
    logic signed [INT_WIDTH-1:0] integ [N_CH];
    logic signed [E_W-1:0]       prev_err [N_CH];

    logic [3:0]                  cur_ch, res_ch;
    logic [CH_W-1:0]             cur_idx;
    logic signed [D_WIDTH-1:0]   cur_t, cur_m, g_p, g_i, g_d, u_q;
    logic signed [E_W-1:0]       e_q, e_c;
    logic signed [DD_W-1:0]      d_q, d_c;
    logic signed [INT_WIDTH-1:0] i_new_q, i_new_c;
    logic signed [INT_WIDTH:0]   i_sum;
    logic signed [SUM_W-1:0]     sum, shifted;
    logic signed [D_WIDTH-1:0]   op_a, u_c;
    logic signed [OP_W-1:0]      op_b;
    logic signed [P_W-1:0]       prod;
    logic [SUM_W-D_WIDTH:0]      upper;
    logic                        ovf, sat_hi, sat_lo, wb_int, res_pend;

    assign cur_idx = cur_ch[CH_W-1:0];

    always_comb begin
        e_c   = {cur_t[D_WIDTH-1], cur_t} - {cur_m[D_WIDTH-1], cur_m};
        d_c   = {e_c[E_W-1], e_c} - {prev_err[cur_idx][E_W-1], prev_err[cur_idx]};
        i_sum = {integ[cur_idx][INT_WIDTH-1], integ[cur_idx]} + (INT_WIDTH+1)'(e_c);
        if (i_sum[INT_WIDTH] != i_sum[INT_WIDTH-1])
            i_new_c = i_sum[INT_WIDTH] ? {1'b1, {(INT_WIDTH-1){1'b0}}} : {1'b0, {(INT_WIDTH-1){1'b1}}};
        else
            i_new_c = i_sum[INT_WIDTH-1:0];

        op_a = '0;
        op_b = '0;
        case (state)
            MUL_P: begin op_a = g_p; op_b = OP_W'(e_q);     end
            MUL_I: begin op_a = g_i; op_b = OP_W'(i_new_q); end
            MUL_D: begin op_a = g_d; op_b = OP_W'(d_q);     end
            default: ;
        endcase
        prod = P_W'(op_a) * P_W'(op_b);

        shifted = sum >>> FRAC_BITS;
        upper   = shifted[SUM_W-1:D_WIDTH-1];
        ovf     = !((&upper) || !(|upper));
        sat_hi  = ovf && !shifted[SUM_W-1];
        sat_lo  = ovf && shifted[SUM_W-1];
        u_c     = sat_hi ? {1'b0, {(D_WIDTH-1){1'b1}}} :
                  sat_lo ? {1'b1, {(D_WIDTH-1){1'b0}}} : shifted[D_WIDTH-1:0];
`ifdef PID_ANTIWINDUP_EN
        wb_int = !((sat_hi && !e_q[E_W-1] && (|e_q)) || (sat_lo && e_q[E_W-1]));
`else
        wb_int = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out          <= '0;
            res_pend     <= 1'b0;
            res_ch       <= '0;
            u_q          <= '0;
            cur_ch       <= '0;
            cur_t        <= '0;
            cur_m        <= '0;
            g_p          <= '0;
            g_i          <= '0;
            g_d          <= '0;
            e_q          <= '0;
            d_q          <= '0;
            i_new_q      <= '0;
            sum          <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                kp[i]       <= '0;
                ki[i]       <= '0;
                kd[i]       <= '0;
                integ[i]    <= '0;
                prev_err[i] <= '0;
            end
        end else begin
            // Result is presented one cycle after SAT so the strobe lands 6 clocks after accept.
            out_valid <= res_pend;
            res_pend  <= 1'b0;
            if (res_pend) begin
                out    <= u_q;
                out_ch <= res_ch;
            end
            case (state)
                IDLE: if (sample_valid && ({1'b0, sample_ch} < 5'(N_CH))) begin
                    state        <= ERR;
                    sample_ready <= 1'b0;
                    cur_ch       <= sample_ch;
                    cur_t        <= target;
                    cur_m        <= measurement;
                    g_p          <= kp[sample_ch[CH_W-1:0]];
                    g_i          <= ki[sample_ch[CH_W-1:0]];
                    g_d          <= kd[sample_ch[CH_W-1:0]];
                end
                ERR: begin
                    e_q     <= e_c;
                    d_q     <= d_c;
                    i_new_q <= i_new_c;
                    state   <= MUL_P;
                end
                MUL_P: begin sum <= SUM_W'(prod);       state <= MUL_I; end
                MUL_I: begin sum <= sum + SUM_W'(prod); state <= MUL_D; end
                MUL_D: begin sum <= sum + SUM_W'(prod); state <= SAT;   end
                SAT: begin
                    u_q               <= u_c;
                    res_ch            <= cur_ch;
                    res_pend          <= 1'b1;
                    prev_err[cur_idx] <= e_q;
                    if (wb_int) integ[cur_idx] <= i_new_q;
                    state             <= IDLE;
                    sample_ready      <= 1'b1;
                end
                default: begin state <= IDLE; sample_ready <= 1'b1; end
            endcase
            // Placed after the SAT write-back so a same-cycle clear overrides it.
            if (write_enable && ({1'b0, reg_addr[15:2]} < 15'(N_CH))) begin
                case (reg_addr[1:0])
                    2'd0: kp[reg_addr[CH_W+1:2]] <= reg_data[D_WIDTH-1:0];
                    2'd1: ki[reg_addr[CH_W+1:2]] <= reg_data[D_WIDTH-1:0];
                    2'd2: kd[reg_addr[CH_W+1:2]] <= reg_data[D_WIDTH-1:0];
                    default: begin
                        integ[reg_addr[CH_W+1:2]]    <= '0;
                        prev_err[reg_addr[CH_W+1:2]] <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pid_multi.sv
// Scoreboard bench for pid_multi: a behavioural model predicts each result at accept time.
module tb_pid_multi;
    localparam int D_WIDTH = 16, N_CH = 4, FRAC_BITS = 8, INT_WIDTH = 24;
    localparam longint I_MAX = 8388607, I_MIN = -8388608;

    logic clock = 1'b0;
    logic reset, write_enable, sample_valid, sample_ready, out_valid;
    logic [15:0] reg_addr, reg_data;
    logic [3:0]  sample_ch, out_ch;
    logic signed [D_WIDTH-1:0] target, measurement, out;

    always #5 clock = ~clock;

    pid_multi #(.D_WIDTH(D_WIDTH), .N_CH(N_CH), .FRAC_BITS(FRAC_BITS), .INT_WIDTH(INT_WIDTH)) dut (
        .clock(clock), .reset(reset), .write_enable(write_enable), .reg_addr(reg_addr),
        .reg_data(reg_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_ch(sample_ch), .target(target), .measurement(measurement),
        .out_valid(out_valid), .out_ch(out_ch), .out(out)
    );

    typedef struct { int ch; longint val; longint due; } exp_t;
    exp_t sb[$];
    exp_t got_x;
    int n_checks = 0, n_errors = 0;
    longint cyc = 0;
    longint m_kp[N_CH], m_ki[N_CH], m_kd[N_CH], m_int[N_CH], m_prev[N_CH];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_kp[i] = 0; m_ki[i] = 0; m_kd[i] = 0; m_int[i] = 0; m_prev[i] = 0;
        end
    endfunction

    function automatic void model_write(input int ch, input int field, input logic [15:0] data);
        if (ch >= N_CH) return;
        case (field)
            0: m_kp[ch] = longint'($signed(data));
            1: m_ki[ch] = longint'($signed(data));
            2: m_kd[ch] = longint'($signed(data));
            default: begin m_int[ch] = 0; m_prev[ch] = 0; end
        endcase
    endfunction

    function automatic longint model(input int ch, input longint t, input longint m);
        longint e, d, inew, s, u;
        bit hi, lo;
        e    = t - m;
        d    = e - m_prev[ch];
        inew = m_int[ch] + e;
        if (inew > I_MAX) inew = I_MAX;
        if (inew < I_MIN) inew = I_MIN;
        s  = m_kp[ch] * e + m_ki[ch] * inew + m_kd[ch] * d;
        u  = s >>> FRAC_BITS;
        hi = (u > 32767);
        lo = (u < -32768);
        if (hi) u = 32767;
        if (lo) u = -32768;
        m_prev[ch] = e;
`ifdef PID_ANTIWINDUP_EN
        if (!((hi && e > 0) || (lo && e < 0))) m_int[ch] = inew;
`else
        m_int[ch] = inew;
`endif
        return u;
    endfunction

    always @(negedge clock) begin
        if (out_valid) begin
            if (sb.size() == 0) check("spurious_out_valid", 1, 0);
            else begin
                got_x = sb.pop_front();
                check("out", longint'(out), got_x.val);
                check("out_ch", longint'(out_ch), longint'(got_x.ch));
                check("latency", cyc, got_x.due);
            end
        end
    end

    task automatic reg_write(input int ch, input int field, input logic [15:0] data);
        @(negedge clock);
        write_enable = 1'b1;
        reg_addr     = 16'(ch * 4 + field);
        reg_data     = data;
        @(posedge clock);
        #1 write_enable = 1'b0;
        model_write(ch, field, data);
    endtask

    task automatic send_raw(input int ch, input int t, input int m, input bit track,
                            input bit wr, input int field, input logic [15:0] data);
        exp_t x;
        int waited = 0;
        @(negedge clock);
        while (!sample_ready && waited < 50) begin @(negedge clock); waited++; end
        if (!sample_ready) check("ready_timeout", 0, 1);
        sample_valid = 1'b1;
        sample_ch    = 4'(ch);
        target       = 16'(t);
        measurement  = 16'(m);
        if (wr) begin
            write_enable = 1'b1;
            reg_addr     = 16'(ch * 4 + field);
            reg_data     = data;
        end
        if (track && ch < N_CH) begin
            x.ch  = ch;
            x.val = model(ch, t, m);
            x.due = cyc + 7;
            sb.push_back(x);
        end
        if (wr) model_write(ch, field, data);
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic send(input int ch, input int t, input int m);
        send_raw(ch, t, m, 1'b1, 1'b0, 0, 16'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clock); n++; end
        check("drain", longint'(sb.size()), 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; write_enable = 1'b0; sample_valid = 1'b0;
        reg_addr = '0; reg_data = '0; sample_ch = '0; target = '0; measurement = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out", longint'(out), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_ch", longint'(out_ch), 0);
        check("rst_ready", longint'(sample_ready), 1);

        // Proportional only, with handshake timing
        reg_write(0, 0, 16'd256);
        send(0, 50, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("ready_busy", longint'(sample_ready), 0);
        end
        @(negedge clock);
        check("ready_back", longint'(sample_ready), 1);
        drain();

        // Gain write on the accept edge: snapshot keeps the old gain
        send_raw(0, 50, 10, 1'b1, 1'b1, 0, 16'd512);
        send(0, 50, 10);
        drain();

        // Integral accumulation and clear
        reg_write(1, 1, 16'd256);
        repeat (3) send(1, 50, 40);
        drain();
        reg_write(1, 3, 16'h0);
        send(1, 50, 40);
        drain();
        // Clear landing on the SAT edge wins over the write-back
        send(1, 50, 40);
        repeat (4) @(negedge clock);
        reg_write(1, 3, 16'h0);
        drain();
        send(1, 50, 40);
        drain();

        // Derivative term
        reg_write(2, 2, 16'd256);
        send(2, 50, 10);
        send(2, 50, 20);
        drain();

        // Output saturation; integral exposed afterwards with Kp=0, e=0
        reg_write(3, 0, 16'd32767);
        reg_write(3, 1, 16'd256);
        repeat (3) send(3, 1000, 0);
        drain();
        reg_write(3, 0, 16'd0);
        send(3, 0, 0);
        drain();

        // Integral accumulator clamps at both ends without wrapping
        reg_write(2, 2, 16'd0);
        reg_write(2, 1, 16'd1);
        reg_write(2, 3, 16'h0);
        repeat (140) send(2, 32767, -32768);
        send(2, 0, 0);
        repeat (140) send(2, -32768, 32767);
        send(2, 0, 0);
        drain();

        // Interleaved channels
        for (int i = 0; i < 6; i++) begin
            send(0, 50 + i, 10);
            send(1, 50, 40 - i);
        end
        drain();

        // Random gains and samples across channels
        for (int i = 0; i < 24; i++) begin
            int ch;
            ch = int'($urandom_range(0, N_CH - 1));
            if ($urandom_range(0, 2) == 0)
                reg_write(ch, int'($urandom_range(0, 2)), 16'($urandom_range(0, 65535)));
            send(ch, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        drain();

        // Out-of-range channel on sample and register paths
        send(5, 50, 10);
        @(negedge clock);
        check("bad_ch_ready", longint'(sample_ready), 1);
        reg_write(4, 0, 16'd999);
        repeat (10) @(negedge clock);
        send(0, 50, 10);
        drain();

        // Reset during MUL_I aborts the sample and clears all gains
        send_raw(0, 50, 10, 1'b0, 1'b0, 0, 16'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("mid_rst_out", longint'(out), 0);
        check("mid_rst_ready", longint'(sample_ready), 1);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        repeat (10) @(negedge clock);
        send(0, 50, 10);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
